echo_cancel_sequencer: RTL and testbench

Handshake-driven frame sequencer for the echo-cancellation datapath. It is the parametrised successor to the fixed-delay top level. It replaces hard-coded wait times with start/done handshakes and supports NUM_CH time-multiplexed channels, each with its own adaptation iteration counter. It also adds a freeze mode and a per-stage timeout. It sits above the sig16b→double converters, the parameter-approximation (LMS) unit, the echo-cancel unit and the double→sig16b output stage, and drives them once per sampling tick.

---
 rtl/echo_cancel_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_echo_cancel_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/echo_cancel_sequencer.sv
// Handshake-driven frame sequencer for the echo-cancellation datapath.
// One frame per sampling tick walks every channel through convert, adapt, cancel and output.

module echo_cancel_lane #(
    parameter int ITER_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              latch_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic              freeze_i,
    input  logic [ITER_W-1:0] max_i,
    input  logic [15:0]       sig_i,
    input  logic [15:0]       lag_i,
    output logic [ITER_W-1:0] iter_o,
    output logic              adapting_o,
    output logic [15:0]       sig_o,
    output logic [15:0]       lag_o
);
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [15:0]       sig_q, lag_q;

    always_comb begin
        iter_d = iter_q;
        // Clear wins over a same-cycle increment; the count saturates at all-ones.
        if (clr_i)
            iter_d = '0;
        else if (inc_i && (iter_q != '1))
            iter_d = iter_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iter_q <= '0;
            sig_q  <= '0;
            lag_q  <= '0;
        end else begin
            iter_q <= iter_d;
            if (latch_i) begin
                sig_q <= sig_i;
                lag_q <= lag_i;
            end
        end
    end

    assign iter_o     = iter_q;
    assign adapting_o = (iter_q < max_i) & ~freeze_i;
    assign sig_o      = sig_q;
    assign lag_o      = lag_q;
endmodule

module echo_cancel_sequencer #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 13,
    parameter int ITER_W  = 13,
    parameter int TIMEOUT = 1024,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_operation,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         sampling_cycle_counter,
    input  logic [ITER_W-1:0]        set_max_iteration,
    input  logic                     adapt_freeze,
    input  logic                     iter_clear,
    input  logic [16*NUM_CH-1:0]     sig16b,
    input  logic [16*NUM_CH-1:0]     sig16b_lag,
    output logic [CH_W-1:0]          ch_sel,
    output logic [15:0]              ch_sig16b,
    output logic [15:0]              ch_sig16b_lag,
    output logic                     conv_start,
    input  logic                     conv_done,
    output logic                     approx_start,
    input  logic                     approx_done,
    output logic                     cancel_start,
    input  logic                     cancel_done,
    output logic                     out_start,
    output logic                     out_sel,
    output logic [ITER_W*NUM_CH-1:0] iteration,
    output logic [NUM_CH-1:0]        adapting,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     timeout_err
);
    localparam int TMO_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        ADAPT,
        CANCEL,
        OUTPUT,
        NEXT_CH
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              cap_q, cap_d;
    logic              ovr_q, ovr_d;
    logic              terr_q, terr_d;

    logic              tick_req, tick, latch;
    logic              in_stage, first, last, stage_done, stage_ok, tmo_fire;
    logic              last_ch;

    logic [NUM_CH-1:0][ITER_W-1:0] lane_iter;
    logic [NUM_CH-1:0][15:0]       lane_sig, lane_lag;

    assign tick_req = enable && (sampling_cycle_counter == '0);
    assign tick     = tick_req && (state_q == IDLE);
    assign latch    = tick;
    assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));

    assign in_stage = (state_q == CONVERT) || (state_q == ADAPT) || (state_q == CANCEL);
    assign first    = (tmo_q == '0);
    assign last     = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        stage_done = 1'b0;
        case (state_q)
            CONVERT: stage_done = conv_done;
            ADAPT:   stage_done = approx_done;
            CANCEL:  stage_done = cancel_done;
            default: stage_done = 1'b0;
        endcase
    end

    // A done arriving together with start belongs to a stale request and is ignored.
    assign stage_ok = in_stage && !first && stage_done;
    assign tmo_fire = in_stage && last && !stage_done;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cap_d   = cap_q;
        ovr_d   = ovr_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    ch_d    = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (stage_ok) begin
                    cap_d   = adapting[ch_q];
                    state_d = adapting[ch_q] ? ADAPT : CANCEL;
                end
            end
            ADAPT:   if (stage_ok) state_d = CANCEL;
            CANCEL:  if (stage_ok) state_d = OUTPUT;
            OUTPUT:  state_d = NEXT_CH;
            NEXT_CH: begin
                if (last_ch) begin
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = CONVERT;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled stage abandons the channel: no output load, no count.
        if (tmo_fire) begin
            state_d = NEXT_CH;
            terr_d  = 1'b1;
        end
        if (tick_req && (state_q != IDLE))
            ovr_d = 1'b1;
        if (iter_clear) begin
            ovr_d  = 1'b0;
            terr_d = 1'b0;
        end

        tmo_d = (in_stage && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge clk_operation or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            tmo_q   <= '0;
            cap_q   <= 1'b0;
            ovr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            tmo_q   <= tmo_d;
            cap_q   <= cap_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        echo_cancel_lane #(.ITER_W(ITER_W)) u_lane (
            .clk_i      (clk_operation),
            .rst_ni     (rst_n),
            .latch_i    (latch),
            .clr_i      (iter_clear),
            .inc_i      ((state_q == OUTPUT) && cap_q && (ch_q == CH_W'(k))),
            .freeze_i   (adapt_freeze),
            .max_i      (set_max_iteration),
            .sig_i      (sig16b[16*k +: 16]),
            .lag_i      (sig16b_lag[16*k +: 16]),
            .iter_o     (lane_iter[k]),
            .adapting_o (adapting[k]),
            .sig_o      (lane_sig[k]),
            .lag_o      (lane_lag[k])
        );
    end

    assign iteration     = lane_iter;
    assign ch_sel        = ch_q;
    assign ch_sig16b     = lane_sig[ch_q];
    assign ch_sig16b_lag = lane_lag[ch_q];

    assign conv_start    = (state_q == CONVERT) && first;
    assign approx_start  = (state_q == ADAPT)   && first;
    assign cancel_start  = (state_q == CANCEL)  && first;
    assign out_start     = (state_q == OUTPUT);
    assign out_sel       = (state_q == OUTPUT) && !cap_q;
    assign frame_done    = (state_q == NEXT_CH) && last_ch;
    assign busy          = (state_q != IDLE);
    assign overrun       = ovr_q;
    assign timeout_err   = terr_q;
endmodule

// File: tb/tb_echo_cancel_sequencer.sv
// Directed bench for echo_cancel_sequencer: two channels, 16-cycle stage timeout.
module tb_echo_cancel_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, enable, adapt_freeze, iter_clear;
    logic [12:0] cnt, smax;
    logic [31:0] sig16b, sig16b_lag;
    logic        ch_sel;
    logic [15:0] ch_sig16b, ch_sig16b_lag;
    logic        conv_start, approx_start, cancel_start;
    logic        conv_done = 1'b0, approx_done = 1'b0, cancel_done = 1'b0;
    logic        out_start, out_sel, busy, frame_done, overrun, timeout_err;
    logic [25:0] iteration;
    logic [1:0]  adapting;

    int nvec = 0, nerr = 0;
    int mode = 0;  // 0: done one cycle after start, 1: done with start and after, 2: withhold approx on ch0
    int r_cv, r_ap, r_cn, r_os, r_sel1, r_lat, r_tmo, r_ch1st;
    logic [1:0]  r_och;
    logic [31:0] r_ss, r_ls;

    echo_cancel_sequencer #(.NUM_CH(2), .CNT_W(13), .ITER_W(13), .TIMEOUT(16)) dut (
        .clk_operation(clk), .rst_n(rst_n), .enable(enable),
        .sampling_cycle_counter(cnt), .set_max_iteration(smax),
        .adapt_freeze(adapt_freeze), .iter_clear(iter_clear),
        .sig16b(sig16b), .sig16b_lag(sig16b_lag),
        .ch_sel(ch_sel), .ch_sig16b(ch_sig16b), .ch_sig16b_lag(ch_sig16b_lag),
        .conv_start(conv_start), .conv_done(conv_done),
        .approx_start(approx_start), .approx_done(approx_done),
        .cancel_start(cancel_start), .cancel_done(cancel_done),
        .out_start(out_start), .out_sel(out_sel), .iteration(iteration),
        .adapting(adapting), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Done responder for the three stage handshakes.
    initial begin
        logic pc, pa, px;
        pc = 0; pa = 0; px = 0;
        forever begin
            @(negedge clk);
            conv_done   = pc || (mode == 1 && conv_start);
            approx_done = (pa && !(mode == 2 && ch_sel == 1'b0)) || (mode == 1 && approx_start);
            cancel_done = px || (mode == 1 && cancel_start);
            pc = conv_start; pa = approx_start; px = cancel_start;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_clear();
        @(negedge clk); iter_clear = 1'b1;
        @(negedge clk); iter_clear = 1'b0;
    endtask

    // One tick, then observe until frame_done (bounded).
    task automatic run_frame(input logic [31:0] s, input logic [31:0] l, input int ovr_at);
        r_cv = 0; r_ap = 0; r_cn = 0; r_os = 0; r_sel1 = 0; r_lat = 0; r_tmo = 0; r_ch1st = 9;
        r_och = '0; r_ss = '0; r_ls = '0;
        sig16b = s; sig16b_lag = l;
        @(negedge clk); cnt = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            cnt = (i == ovr_at) ? 13'd0 : 13'd7;
            if (i == 1) begin sig16b = ~s; sig16b_lag = ~l; r_ch1st = int'(ch_sel); end
            if (conv_start) r_cv++;
            if (approx_start) r_ap++;
            if (cancel_start) r_cn++;
            if (out_start) begin
                r_os++;
                if (out_sel) r_sel1++;
                r_och[ch_sel] = 1'b1;
                r_ss[16*ch_sel +: 16] = ch_sig16b;
                r_ls[16*ch_sel +: 16] = ch_sig16b_lag;
            end
            if (timeout_err && r_tmo == 0) r_tmo = i;
            if (frame_done) begin r_lat = i; break; end
        end
    endtask

    task automatic test_reset();
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %0h exp 0", busy); end
        nvec++; if ({conv_start, approx_start, cancel_start, out_start, out_sel, frame_done} !== 6'b0) begin
            nerr++; $display("FAIL reset_pulses got %b exp 000000", {conv_start, approx_start, cancel_start, out_start, out_sel, frame_done}); end
        nvec++; if (iteration !== 26'd0) begin nerr++; $display("FAIL reset_iter got %0h exp 0", iteration); end
        nvec++; if ({overrun, timeout_err, ch_sel} !== 3'b0) begin nerr++; $display("FAIL reset_status got %b exp 000", {overrun, timeout_err, ch_sel}); end
        nvec++; if (ch_sig16b !== 16'h0) begin nerr++; $display("FAIL reset_sample got %h exp 0000", ch_sig16b); end
        nvec++; if (adapting !== 2'b11) begin nerr++; $display("FAIL reset_adapting got %b exp 11", adapting); end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        @(negedge clk); cnt = '0;
        @(negedge clk); cnt = 13'd7;
        @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL enable_off_busy got %0h exp 0", busy); end
        enable = 1'b1;
    endtask

    task automatic test_adapt();
        for (int k = 1; k <= 3; k++) begin
            run_frame(32'hB222_A111, 32'hD444_C333, 0);
            nvec++; if (r_lat !== 16) begin nerr++; $display("FAIL adapt_lat%0d got %0d exp 16", k, r_lat); end
            nvec++; if ({r_cv, r_ap, r_cn, r_os, r_sel1} !== {32'd2, 32'd2, 32'd2, 32'd2, 32'd0}) begin
                nerr++; $display("FAIL adapt_pulses%0d got %0d %0d %0d %0d %0d exp 2 2 2 2 0", k, r_cv, r_ap, r_cn, r_os, r_sel1); end
            nvec++; if (iteration !== {13'(k), 13'(k)}) begin nerr++; $display("FAIL adapt_iter%0d got %h exp %0d,%0d", k, iteration, k, k); end
        end
        nvec++; if (r_ss !== 32'hB222_A111) begin nerr++; $display("FAIL latched_sig got %h exp b222a111", r_ss); end
        nvec++; if (r_ls !== 32'hD444_C333) begin nerr++; $display("FAIL latched_lag got %h exp d444c333", r_ls); end
        nvec++; if (adapting !== 2'b00) begin nerr++; $display("FAIL adapt_done_flag got %b exp 00", adapting); end
        run_frame(32'h1234_5678, 32'h9ABC_DEF0, 0);
        nvec++; if (r_lat !== 12) begin nerr++; $display("FAIL noadapt_lat got %0d exp 12", r_lat); end
        nvec++; if ({r_ap, r_os, r_sel1} !== {32'd0, 32'd2, 32'd2}) begin nerr++; $display("FAIL noadapt_pulses got %0d %0d %0d exp 0 2 2", r_ap, r_os, r_sel1); end
        nvec++; if (iteration !== {13'd3, 13'd3}) begin nerr++; $display("FAIL noadapt_iter got %h exp 3,3", iteration); end
    endtask

    task automatic test_freeze();
        pulse_clear();
        nvec++; if (iteration !== 26'd0) begin nerr++; $display("FAIL freeze_clear got %h exp 0", iteration); end
        run_frame(32'h0001_0002, 32'h0003_0004, 0);
        adapt_freeze = 1'b1;
        @(negedge clk);
        nvec++; if (adapting !== 2'b00) begin nerr++; $display("FAIL freeze_flag got %b exp 00", adapting); end
        run_frame(32'h0001_0002, 32'h0003_0004, 0);
        nvec++; if ({r_ap, r_sel1, r_lat} !== {32'd0, 32'd2, 32'd12}) begin nerr++; $display("FAIL freeze_frame got %0d %0d %0d exp 0 2 12", r_ap, r_sel1, r_lat); end
        nvec++; if (iteration !== {13'd1, 13'd1}) begin nerr++; $display("FAIL freeze_hold got %h exp 1,1", iteration); end
        adapt_freeze = 1'b0;
        run_frame(32'h0001_0002, 32'h0003_0004, 0);
        run_frame(32'h0001_0002, 32'h0003_0004, 0);
        nvec++; if ({r_ap, r_sel1} !== {32'd2, 32'd0}) begin nerr++; $display("FAIL unfreeze_frame got %0d %0d exp 2 0", r_ap, r_sel1); end
        nvec++; if (iteration !== {13'd3, 13'd3}) begin nerr++; $display("FAIL unfreeze_iter got %h exp 3,3", iteration); end
    endtask

    task automatic test_same_cycle_done();
        pulse_clear();
        mode = 1;
        run_frame(32'h5555_AAAA, 32'h0F0F_F0F0, 0);
        mode = 0;
        nvec++; if (r_lat !== 16) begin nerr++; $display("FAIL samecyc_lat got %0d exp 16", r_lat); end
        nvec++; if ({r_ap, r_os} !== {32'd2, 32'd2}) begin nerr++; $display("FAIL samecyc_pulses got %0d %0d exp 2 2", r_ap, r_os); end
    endtask

    task automatic test_timeout();
        pulse_clear();
        mode = 2;
        run_frame(32'h0, 32'h0, 0);
        mode = 0;
        nvec++; if (r_tmo !== 19) begin nerr++; $display("FAIL tmo_time got %0d exp 19", r_tmo); end
        nvec++; if (timeout_err !== 1'b1) begin nerr++; $display("FAIL tmo_flag got %0h exp 1", timeout_err); end
        nvec++; if ({r_os, 30'd0, r_och} !== {32'd1, 32'd2}) begin nerr++; $display("FAIL tmo_out got %0d mask %b exp 1 mask 10", r_os, r_och); end
        nvec++; if (iteration !== {13'd1, 13'd0}) begin nerr++; $display("FAIL tmo_iter got %h exp 1,0", iteration); end
        nvec++; if ({r_ap, r_lat} !== {32'd2, 32'd27}) begin nerr++; $display("FAIL tmo_ch1 got %0d %0d exp 2 27", r_ap, r_lat); end
    endtask

    task automatic test_overrun();
        run_frame(32'h0, 32'h0, 5);
        nvec++; if ({r_cv, r_lat} !== {32'd2, 32'd16}) begin nerr++; $display("FAIL ovr_frame got %0d %0d exp 2 16", r_cv, r_lat); end
        nvec++; if ({overrun, timeout_err} !== 2'b11) begin nerr++; $display("FAIL ovr_flags got %b exp 11", {overrun, timeout_err}); end
        repeat (3) @(negedge clk);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ovr_restart got %0h exp 0", busy); end
        pulse_clear();
        nvec++; if ({iteration, overrun, timeout_err} !== 28'd0) begin
            nerr++; $display("FAIL clear_all got %h %0h %0h exp 0 0 0", iteration, overrun, timeout_err); end
    endtask

    task automatic test_reset_midframe();
        logic seen, bad;
        run_frame(32'h0, 32'h0, 0);
        sig16b = 32'hCAFE_BEEF; sig16b_lag = 32'h1111_2222;
        @(negedge clk); cnt = '0;
        @(negedge clk); cnt = 13'd7;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cancel_start) seen = 1'b1; else @(negedge clk);
        end
        nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL rstmid_reach got %0h exp 1", seen); end
        rst_n = 1'b0;
        #1;
        nvec++; if ({busy, cancel_start, out_start, frame_done, ch_sel} !== 5'b0) begin
            nerr++; $display("FAIL rstmid_outputs got %b exp 00000", {busy, cancel_start, out_start, frame_done, ch_sel}); end
        nvec++; if ({iteration, ch_sig16b} !== 42'd0) begin nerr++; $display("FAIL rstmid_state got %h %h exp 0 0", iteration, ch_sig16b); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || conv_start || approx_start || cancel_start || out_start || frame_done) bad = 1'b1;
        end
        nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL rstmid_quiet got %0h exp 0", bad); end
        run_frame(32'h0BAD_F00D, 32'h0, 0);
        nvec++; if ({r_ch1st, r_lat} !== {32'd0, 32'd16}) begin nerr++; $display("FAIL rstmid_restart got ch%0d lat %0d exp ch0 lat 16", r_ch1st, r_lat); end
        nvec++; if (iteration !== {13'd1, 13'd1}) begin nerr++; $display("FAIL rstmid_iter got %h exp 1,1", iteration); end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; adapt_freeze = 1'b0; iter_clear = 1'b0;
        cnt = 13'd7; smax = 13'd3; sig16b = 32'hFFFF_FFFF; sig16b_lag = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_enable();
        test_adapt();
        test_freeze();
        test_same_cycle_done();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
